mem_stage: RTL and testbench

- Memory-access stage of the 5-stage multi-cycle core.
- Sits downstream of the control unit's execute step and upstream of write-back.
- On a start pulse from control, performs one load or store against the shared RAM port, with byte/half/word lane steering and sign/zero extension.
- Returns a registered load result and a one-cycle done pulse to control.

---
 rtl/mem_stage.sv | 151 +++++++++++++++
 tb/tb_mem_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: one load or store per start pulse, with lane steering and load extension.
// Optional MISALIGN_TRAP_EN rejects misaligned halfword/word accesses instead of aligning them.
module mem_stage #(
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            is_store_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic [XLEN-1:0] load_data_o,
  output logic [XLEN-1:0] ram_addr_o,
  output logic            ram_we_o,
  output logic [3:0]      ram_be_o,
  output logic [XLEN-1:0] ram_data_o,
  input  logic [XLEN-1:0] ram_data_i
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

  localparam logic [1:0] WaitInit = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

  state_e          state_q;
  logic            is_store_q;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic [1:0]      cnt_q;

  logic            reject;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_val;

  always_comb begin
    reject = is_store_i ? (funct3_i[2] | (funct3_i[1:0] == 2'b11))
                        : ((funct3_i == 3'b011) | (funct3_i[2:1] == 2'b11));
`ifdef MISALIGN_TRAP_EN
    if ((funct3_i[1:0] == 2'b01) && addr_i[0]) reject = 1'b1;
    if ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)) reject = 1'b1;
`endif
  end

  always_comb begin
    st_be   = 4'b1111;
    st_data = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        st_be   = 4'b0001 << addr_i[1:0];
        st_data = {(XLEN/8){wdata_i[7:0]}};
      end
      2'b01: begin
        st_be   = addr_i[1] ? 4'b1100 : 4'b0011;
        st_data = {(XLEN/16){wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ram_data_i[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? ram_data_i[31:16] : ram_data_i[15:0];
    case (funct3_q)
      3'b000:  ld_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_val = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_val = ram_data_i;
    endcase
  end

  // Outputs are registered and updated on the same edge as the state they belong to.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      is_store_q  <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      cnt_q       <= 2'b00;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      load_data_o <= '0;
      ram_addr_o  <= '0;
      ram_we_o    <= 1'b0;
      ram_be_o    <= 4'b0000;
      ram_data_o  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            is_store_q <= is_store_i;
            funct3_q   <= funct3_i;
            off_q      <= addr_i[1:0];
            busy_o     <= 1'b1;
            if (reject) begin
              state_q <= StDone;
              done_o  <= 1'b1;
              err_o   <= 1'b1;
            end else begin
              state_q    <= StReq;
              ram_addr_o <= {addr_i[XLEN-1:2], 2'b00};
              ram_we_o   <= is_store_i;
              ram_be_o   <= is_store_i ? st_be : 4'b0000;
              ram_data_o <= is_store_i ? st_data : '0;
            end
          end
        end
        StReq: begin
          ram_we_o   <= 1'b0;
          ram_be_o   <= 4'b0000;
          ram_data_o <= '0;
          if (is_store_q || (RD_LATENCY == 0)) begin
            state_q    <= StDone;
            done_o     <= 1'b1;
            ram_addr_o <= '0;
            if (!is_store_q) load_data_o <= ld_val;
          end else begin
            state_q <= StWait;
            cnt_q   <= WaitInit;
          end
        end
        StWait: begin
          if (cnt_q == 2'd0) begin
            state_q     <= StDone;
            done_o      <= 1'b1;
            ram_addr_o  <= '0;
            load_data_o <= ld_val;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
          err_o   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random loads/stores against a word-array model.
module tb_mem_stage;
  localparam int unsigned LAT = 1;

  logic        clk = 1'b0;
  logic        reset, start, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        busy_o, done_o, err_o, ram_we_o;
  logic [31:0] load_data_o, ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0]  ram_be_o;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] rd_q;
  logic        fill;
  logic [31:0] model_ld;

  always #5 clk = ~clk;

  mem_stage #(.RD_LATENCY(LAT), .XLEN(32)) dut (
    .clk(clk), .reset(reset), .start_i(start), .is_store_i(is_store), .funct3_i(funct3),
    .addr_i(addr), .wdata_i(wdata), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .load_data_o(load_data_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o),
    .ram_be_o(ram_be_o), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  // RAM with one cycle of read latency; fill copies the model image in as a backdoor preload.
  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < 256; i++) mem[i] <= ref_mem[i];
    end else if (ram_we_o) begin
      for (int i = 0; i < 4; i++)
        if (ram_be_o[i]) mem[ram_addr_o[9:2]][8*i +: 8] <= ram_data_o[8*i +: 8];
    end
    rd_q <= mem[ram_addr_o[9:2]];
  end
  assign ram_data_i = rd_q;

  function automatic logic ref_rejected(logic st, logic [2:0] f3, logic [31:0] a);
    logic bad;
    if (st) bad = !(f3 inside {3'd0, 3'd1, 3'd2});
    else    bad = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
`ifdef MISALIGN_TRAP_EN
    if (f3[1:0] == 2'd1 && a[0]) bad = 1'b1;
    if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] ref_load(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(logic [2:0] f3, logic [1:0] off);
    if (f3 == 3'd0) return 4'(1 << off);
    if (f3 == 3'd1) return (off >= 2) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] ref_sdata(logic [2:0] f3, logic [31:0] w);
    if (f3 == 3'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  task automatic apply_store_to_model(logic [31:0] a, logic [3:0] be, logic [31:0] d);
    for (int i = 0; i < 4; i++)
      if (be[i]) ref_mem[a[9:2]][8*i +: 8] = d[8*i +: 8];
  endtask

  // Drives one request and records what the DUT did; returns one cycle after done_o (state IDLE).
  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output int lat, output logic e,
                       output logic [31:0] ld, output int wec, output logic [31:0] wa,
                       output logic [3:0] wbe, output logic [31:0] wdo,
                       output logic [31:0] ra, output logic idle_busy);
    is_store = st; funct3 = f3; addr = a; wdata = wd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 99; e = 1'b0; wec = 0; wa = '0; wbe = '0; wdo = '0; ra = ram_addr_o;
    for (int c = 1; c <= 20; c++) begin
      if (ram_we_o) begin
        wec++; wa = ram_addr_o; wbe = ram_be_o; wdo = ram_data_o;
      end
      if (done_o) begin
        lat = c; e = err_o;
        break;
      end
      @(posedge clk); #1;
    end
    ld = load_data_o;
    @(posedge clk); #1;
    idle_busy = busy_o;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    fill = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    fill = 1'b0;
    model_ld = '0;
    n_cmp++;
    if ({busy_o, done_o, err_o, ram_we_o, ram_be_o} !== 8'h00 || load_data_o !== 32'h0 ||
        ram_addr_o !== 32'h0 || ram_data_o !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b we=%b be=%b ld=%h ra=%h rd=%h want all 0",
               busy_o, done_o, err_o, ram_we_o, ram_be_o, load_data_o, ram_addr_o, ram_data_o);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int lat, wec; logic e, ib; logic [31:0] ld, wa, wdo, ra; logic [3:0] wbe;
    issue(1'b0, 3'd2, 32'h104, 32'h0, lat, e, ld, wec, wa, wbe, wdo, ra, ib);
    n_cmp++; if (ra !== 32'h104) begin n_bad++; $display("FAIL lw_req_addr: got %h want 00000104", ra); end
    n_cmp++; if (lat !== 2 + LAT) begin n_bad++; $display("FAIL lw_latency: got %0d want %0d", lat, 2 + LAT); end
    n_cmp++; if (ld !== 32'h8899AABB || e !== 1'b0) begin
      n_bad++; $display("FAIL lw_data: got %h err=%b want 8899aabb err=0", ld, e); end
    issue(1'b0, 3'd0, 32'h107, 32'h0, lat, e, ld, wec, wa, wbe, wdo, ra, ib);
    n_cmp++; if (ld !== 32'hFFFFFF88) begin n_bad++; $display("FAIL lb_sext: got %h want ffffff88", ld); end
    issue(1'b0, 3'd4, 32'h107, 32'h0, lat, e, ld, wec, wa, wbe, wdo, ra, ib);
    n_cmp++; if (ld !== 32'h00000088) begin n_bad++; $display("FAIL lbu_zext: got %h want 00000088", ld); end
    model_ld = 32'h00000088;
    issue(1'b1, 3'd1, 32'h202, 32'h1234ABCD, lat, e, ld, wec, wa, wbe, wdo, ra, ib);
    apply_store_to_model(32'h200, 4'b1100, 32'hABCDABCD);
    n_cmp++; if (wec !== 1 || wa !== 32'h200 || wbe !== 4'b1100 || wdo !== 32'hABCDABCD) begin
      n_bad++; $display("FAIL sh_ram: got we=%0d a=%h be=%b d=%h want 1 00000200 1100 abcdabcd",
                        wec, wa, wbe, wdo); end
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL sh_latency: got %0d want 2", lat); end
    n_cmp++; if (ld !== model_ld) begin n_bad++; $display("FAIL sh_ld_held: got %h want %h", ld, model_ld); end
  endtask

  task automatic test_illegal();
    int lat, wec; logic e, ib; logic [31:0] ld, wa, wdo, ra; logic [3:0] wbe;
    issue(1'b0, 3'd7, 32'h104, 32'h0, lat, e, ld, wec, wa, wbe, wdo, ra, ib);
    n_cmp++; if (wec !== 0 || e !== 1'b1 || lat !== 1) begin
      n_bad++; $display("FAIL illegal_ld: got we=%0d err=%b lat=%0d want 0 1 1", wec, e, lat); end
    n_cmp++; if (ld !== model_ld) begin n_bad++; $display("FAIL illegal_ld_held: got %h want %h", ld, model_ld); end
    issue(1'b1, 3'd3, 32'h104, 32'hFFFFFFFF, lat, e, ld, wec, wa, wbe, wdo, ra, ib);
    n_cmp++; if (wec !== 0 || e !== 1'b1 || lat !== 1) begin
      n_bad++; $display("FAIL illegal_st: got we=%0d err=%b lat=%0d want 0 1 1", wec, e, lat); end
  endtask

  task automatic test_misalign();
    int lat, wec; logic e, ib; logic [31:0] ld, wa, wdo, ra; logic [3:0] wbe;
    issue(1'b0, 3'd2, 32'h101, 32'h0, lat, e, ld, wec, wa, wbe, wdo, ra, ib);
`ifdef MISALIGN_TRAP_EN
    n_cmp++; if (e !== 1'b1 || lat !== 1 || ld !== model_ld) begin
      n_bad++; $display("FAIL misalign_lw: got err=%b lat=%0d ld=%h want 1 1 %h", e, lat, ld, model_ld); end
`else
    model_ld = ref_mem[8'h40];
    n_cmp++; if (e !== 1'b0 || ra !== 32'h100 || ld !== model_ld) begin
      n_bad++; $display("FAIL misalign_lw: got err=%b ra=%h ld=%h want 0 00000100 %h", e, ra, ld, model_ld); end
`endif
  endtask

  task automatic test_random();
    int lat, wec, exp_lat; logic e, ib, st, rej; logic [31:0] ld, wa, wdo, ra, a, wd, ea;
    logic [3:0] wbe; logic [2:0] f3;
    for (int i = 0; i < 80; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 5) != 0) f3 = st ? 3'($urandom_range(0, 2)) : (($urandom_range(0, 1) == 1) ?
                                               3'($urandom_range(4, 5)) : 3'($urandom_range(0, 2)));
      a  = 32'($urandom_range(0, 1023));
      wd = $urandom;
      rej = ref_rejected(st, f3, a);
      exp_lat = rej ? 1 : (st ? 2 : 2 + int'(LAT));
      ea = a & 32'hFFFF_FFFC;
      issue(st, f3, a, wd, lat, e, ld, wec, wa, wbe, wdo, ra, ib);
      if (!st && !rej) model_ld = ref_load(ref_mem[a[9:2]], f3, a[1:0]);
      n_cmp++; if (lat !== exp_lat || e !== rej) begin
        n_bad++; $display("FAIL rnd_done[%0d]: got lat=%0d err=%b want %0d %b", i, lat, e, exp_lat, rej); end
      n_cmp++; if (ld !== model_ld) begin
        n_bad++; $display("FAIL rnd_load[%0d]: got %h want %h (f3=%0d a=%h)", i, ld, model_ld, f3, a); end
      n_cmp++; if (wec !== ((st && !rej) ? 1 : 0)) begin
        n_bad++; $display("FAIL rnd_we_count[%0d]: got %0d want %0d", i, wec, (st && !rej) ? 1 : 0); end
      n_cmp++; if (ib !== 1'b0) begin n_bad++; $display("FAIL rnd_idle_busy[%0d]: got %b want 0", i, ib); end
      if (!rej) begin
        n_cmp++; if (ra !== ea) begin n_bad++; $display("FAIL rnd_req_addr[%0d]: got %h want %h", i, ra, ea); end
      end
      if (st && !rej) begin
        n_cmp++;
        if (wa !== ea || wbe !== ref_be(f3, a[1:0]) || wdo !== ref_sdata(f3, wd)) begin
          n_bad++; $display("FAIL rnd_store[%0d]: got a=%h be=%b d=%h want %h %b %h", i, wa, wbe, wdo,
                            ea, ref_be(f3, a[1:0]), ref_sdata(f3, wd)); end
        apply_store_to_model(a, ref_be(f3, a[1:0]), ref_sdata(f3, wd));
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, wec; logic e, ib; logic [31:0] ld, wa, wdo, ra; logic [3:0] wbe;
    is_store = 1'b0; funct3 = 3'd2; addr = 32'h104; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    model_ld = '0;
    n_cmp++; if (busy_o !== 1'b0 || done_o !== 1'b0 || load_data_o !== 32'h0 || ram_we_o !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset: got busy=%b done=%b ld=%h we=%b want 0 0 0 0",
                        busy_o, done_o, load_data_o, ram_we_o); end
    reset = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 3'd1, 32'h106, 32'h0, lat, e, ld, wec, wa, wbe, wdo, ra, ib);
    model_ld = ref_load(ref_mem[8'h41], 3'd1, 2'd2);
    n_cmp++; if (ld !== model_ld || lat !== 2 + LAT || e !== 1'b0) begin
      n_bad++; $display("FAIL after_reset_lh: got ld=%h lat=%0d err=%b want %h %0d 0",
                        ld, lat, e, model_ld, 2 + LAT); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = $urandom;
    ref_mem[8'h41] = 32'h8899AABB;
    test_reset();
    test_directed();
    test_illegal();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
